oled_ram_wr_arbiter: RTL and testbench

Shares the single write port of the display RAM (ram_show, 1024 x 8) between N write requesters, such as the static-image writer, the char/num renderers and future widgets. This replaces the change_show hard mux. Each requester asks for exclusive ownership with a req/gnt handshake and holds the port for a whole glyph burst. The block also sequences a built-in full-RAM clear, and protects the port with a hold timeout. It sits on clk_1m between the writer modules and the RAM.

---
 rtl/oled_pkg.sv | 18 +
 rtl/oled_rr_pick.sv | 35 +++
 rtl/oled_ram_wr_arbiter.sv | 175 +++++++++++++++++
 tb/tb_oled_ram_wr_arbiter.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/oled_pkg.sv
// oled_pkg: shared OLED display-RAM constants and write-arbiter state encoding
// Holds the display RAM geometry (1024 x 8), the default clear fill value and
// the arbiter FSM states used by oled_ram_wr_arbiter.
package oled_pkg;

    localparam int OLED_RAM_DEPTH = 1024;
    localparam int OLED_RAM_AW    = 10;
    localparam int OLED_RAM_DW    = 8;

    localparam logic [OLED_RAM_DW-1:0] OLED_CLR_FILL = 8'h00;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_GRANT,
        ARB_CLEAR
    } arb_state_t;

endpackage

// File: rtl/oled_rr_pick.sv
// oled_rr_pick: combinational rotating-priority encoder
// Ports:
//   req     in  N        request vector
//   rr_ptr  in  PW       index with highest priority this cycle
//   winner  out N        one-hot first set bit of req at or above rr_ptr, wrapping
//   valid   out 1        any request present
module oled_rr_pick #(
    parameter int N  = 3,
    parameter int PW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] rr_ptr,
    output logic [N-1:0]  winner,
    output logic          valid
);

    // Two passes: indices at/above the pointer first, then the wrapped range.
    always_comb begin
        winner = '0;
        valid  = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (!valid && req[i] && i >= int'(rr_ptr)) begin
                winner[i] = 1'b1;
                valid     = 1'b1;
            end
        end
        for (int i = 0; i < N; i++) begin
            if (!valid && req[i] && i < int'(rr_ptr)) begin
                winner[i] = 1'b1;
                valid     = 1'b1;
            end
        end
    end

endmodule

// File: rtl/oled_ram_wr_arbiter.sv
// oled_ram_wr_arbiter: round-robin owner of the display RAM write port with built-in clear and hold timeout
// Ports:
//   clk, rst             clock (clk_1m) and synchronous active-high reset
//   req                  per-requester ownership request (level)
//   wren_i/wraddress_i/data_i  per-requester write bus, requester i at slice i
//   clr_req              single-cycle pulse requesting a full-RAM clear
//   gnt                  registered one-hot grant
//   wren/wraddress/data  registered RAM write port
//   clr_busy, clr_done   clear running / one-cycle done pulse
//   timeout_err          one-cycle pulse on forced revoke
module oled_ram_wr_arbiter
    import oled_pkg::*;
#(
    parameter int                 N_REQ    = 3,
    parameter int                 ADDR_W   = OLED_RAM_AW,
    parameter int                 DATA_W   = OLED_RAM_DW,
    parameter int                 DEPTH    = OLED_RAM_DEPTH,
    parameter logic [DATA_W-1:0]  CLR_VAL  = DATA_W'(OLED_CLR_FILL),
    parameter int                 MAX_HOLD = 2048
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N_REQ-1:0]          req,
    input  logic [N_REQ-1:0]          wren_i,
    input  logic [N_REQ*ADDR_W-1:0]   wraddress_i,
    input  logic [N_REQ*DATA_W-1:0]   data_i,
    input  logic                      clr_req,
    output logic [N_REQ-1:0]          gnt,
    output logic                      wren,
    output logic [ADDR_W-1:0]         wraddress,
    output logic [DATA_W-1:0]         data,
    output logic                      clr_busy,
    output logic                      clr_done,
    output logic                      timeout_err
);

    localparam int PW = $clog2(N_REQ);
    localparam int HW = $clog2(MAX_HOLD);

    arb_state_t        state, state_d;
    logic [PW-1:0]     rr_ptr, rr_ptr_d, owner, owner_d, win_idx;
    logic [HW-1:0]     hold_cnt, hold_cnt_d;
    logic [ADDR_W-1:0] clr_addr, clr_addr_d;
    logic              clr_pending, clr_pending_d;
    logic [N_REQ-1:0]  win, gnt_d;
    logic              win_valid;
    logic              own_req, own_wren;
    logic [ADDR_W-1:0] own_addr;
    logic [DATA_W-1:0] own_data;
    logic              wren_d, clr_busy_d, clr_done_d, timeout_err_d;
    logic [ADDR_W-1:0] wraddress_d;
    logic [DATA_W-1:0] data_d;

    oled_rr_pick #(.N(N_REQ), .PW(PW)) u_pick (
        .req    (req),
        .rr_ptr (rr_ptr),
        .winner (win),
        .valid  (win_valid)
    );

    // Owner's bus selected by index; winner one-hot converted back to an index.
    always_comb begin
        own_req  = 1'b0;
        own_wren = 1'b0;
        own_addr = '0;
        own_data = '0;
        win_idx  = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (owner == PW'(i)) begin
                own_req  = req[i];
                own_wren = wren_i[i];
                own_addr = wraddress_i[i*ADDR_W +: ADDR_W];
                own_data = data_i[i*DATA_W +: DATA_W];
            end
            if (win[i])
                win_idx = PW'(i);
        end
    end

    always_comb begin
        state_d       = state;
        rr_ptr_d      = rr_ptr;
        owner_d       = owner;
        hold_cnt_d    = hold_cnt;
        clr_addr_d    = clr_addr;
        clr_pending_d = clr_pending | (clr_req && state != ARB_IDLE);
        gnt_d         = '0;
        wren_d        = 1'b0;
        wraddress_d   = wraddress;
        data_d        = data;
        clr_busy_d    = 1'b0;
        clr_done_d    = 1'b0;
        timeout_err_d = 1'b0;
        case (state)
            ARB_IDLE: begin
                // First clear write is issued on entry so clr_busy covers exactly the writes.
                if (clr_pending || clr_req) begin
                    state_d       = ARB_CLEAR;
                    clr_pending_d = 1'b0;
                    clr_busy_d    = 1'b1;
                    clr_addr_d    = '0;
                    wren_d        = 1'b1;
                    wraddress_d   = '0;
                    data_d        = CLR_VAL;
                end else if (win_valid) begin
                    state_d    = ARB_GRANT;
                    gnt_d      = win;
                    owner_d    = win_idx;
                    hold_cnt_d = '0;
                end
            end
            ARB_GRANT: begin
                if (!own_req || hold_cnt == HW'(MAX_HOLD - 1)) begin
                    state_d       = ARB_IDLE;
                    rr_ptr_d      = (owner == PW'(N_REQ - 1)) ? '0 : owner + 1'b1;
                    timeout_err_d = own_req;
                end else begin
                    gnt_d       = gnt;
                    wren_d      = own_wren;
                    wraddress_d = own_addr;
                    data_d      = own_data;
                    hold_cnt_d  = hold_cnt + 1'b1;
                end
            end
            ARB_CLEAR: begin
                // clr_addr tracks the address currently presented on the RAM port.
                if (clr_addr == ADDR_W'(DEPTH - 1)) begin
                    state_d    = ARB_IDLE;
                    clr_done_d = 1'b1;
                    clr_addr_d = '0;
                end else begin
                    clr_busy_d  = 1'b1;
                    wren_d      = 1'b1;
                    clr_addr_d  = clr_addr + 1'b1;
                    wraddress_d = clr_addr + 1'b1;
                    data_d      = CLR_VAL;
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ARB_IDLE;
            rr_ptr      <= '0;
            owner       <= '0;
            hold_cnt    <= '0;
            clr_addr    <= '0;
            clr_pending <= 1'b0;
            gnt         <= '0;
            wren        <= 1'b0;
            wraddress   <= '0;
            data        <= '0;
            clr_busy    <= 1'b0;
            clr_done    <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            state       <= state_d;
            rr_ptr      <= rr_ptr_d;
            owner       <= owner_d;
            hold_cnt    <= hold_cnt_d;
            clr_addr    <= clr_addr_d;
            clr_pending <= clr_pending_d;
            gnt         <= gnt_d;
            wren        <= wren_d;
            wraddress   <= wraddress_d;
            data        <= data_d;
            clr_busy    <= clr_busy_d;
            clr_done    <= clr_done_d;
            timeout_err <= timeout_err_d;
        end
    end

endmodule

// File: tb/tb_oled_ram_wr_arbiter.sv
// tb_oled_ram_wr_arbiter: table-driven and directed checks of oled_ram_wr_arbiter
module tb_oled_ram_wr_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [2:0]  req = '0;
    logic [2:0]  wren_i = '0;
    logic [29:0] wraddress_i = '0;
    logic [23:0] data_i = '0;
    logic        clr_req = 1'b0;
    logic [2:0]  gnt;
    logic        wren;
    logic [9:0]  wraddress;
    logic [7:0]  data;
    logic        clr_busy, clr_done, timeout_err;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    oled_ram_wr_arbiter #(.N_REQ(3), .MAX_HOLD(16)) dut (
        .clk(clk), .rst(rst), .req(req), .wren_i(wren_i), .wraddress_i(wraddress_i),
        .data_i(data_i), .clr_req(clr_req), .gnt(gnt), .wren(wren), .wraddress(wraddress),
        .data(data), .clr_busy(clr_busy), .clr_done(clr_done), .timeout_err(timeout_err)
    );

    typedef struct {
        logic       rst;
        logic [2:0] req;
        logic [2:0] wen;
        logic [9:0] base;
        logic [7:0] dbase;
        logic [2:0] egnt;
        logic       ewren;
        logic [9:0] eaddr;
        logic [7:0] edata;
    } vec_t;

    vec_t vq[$];

    function automatic void add(input logic r, input logic [2:0] rq, wn, input logic [9:0] b,
                                input logic [7:0] d, input logic [2:0] eg, input logic ew,
                                input logic [9:0] ea, input logic [7:0] ed);
        vq.push_back('{r, rq, wn, b, d, eg, ew, ea, ed});
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Requester i drives address base+256*i and data dbase+16*i.
    task automatic drive(input logic [2:0] r, input logic [2:0] w, input logic [9:0] b, input logic [7:0] d);
        req    = r;
        wren_i = w;
        for (int i = 0; i < 3; i++) begin
            wraddress_i[i*10 +: 10] = b + 10'(i * 256);
            data_i[i*8 +: 8]        = d + 8'(i * 16);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int hold, nwr, nbusy, ndone, gbad, bad, reached;
        logic [9:0] ea;
        // reset with all requests high, then first grant to requester 0
        for (int k = 0; k < 3; k++) add(1, 3'b111, 0, 0, 0, 3'b000, 0, 0, 0);
        add(0, 3'b111, 0, 0, 0, 3'b001, 0, 0, 0);
        add(0, 3'b110, 0, 0, 0, 3'b000, 0, 0, 0);
        add(0, 3'b000, 0, 0, 0, 3'b000, 0, 0, 0);
        // single burst by requester 1, non-owner wren ignored on the middle write
        add(0, 3'b010, 3'b000, 0, 8'h00, 3'b010, 0, 0, 0);
        add(0, 3'b010, 3'b010, 5, 8'hA1, 3'b010, 1, 10'd261, 8'hB1);
        add(0, 3'b010, 3'b111, 6, 8'hA2, 3'b010, 1, 10'd262, 8'hB2);
        add(0, 3'b010, 3'b010, 7, 8'hA3, 3'b010, 1, 10'd263, 8'hB3);
        add(0, 3'b000, 3'b000, 0, 8'h00, 3'b000, 0, 0, 0);
        add(1, 3'b000, 3'b000, 0, 8'h00, 3'b000, 0, 0, 0);
        // round robin 0,1,2,0 with all requesters driving wren
        add(0, 3'b111, 0, 0, 0, 3'b001, 0, 0, 0);
        for (int k = 0; k < 4; k++) add(0, 3'b111, 3'b111, 10'(16 + k), 8'(8'h10 + k), 3'b001, 1, 10'(16 + k), 8'(8'h10 + k));
        add(0, 3'b110, 0, 0, 0, 3'b000, 0, 0, 0);
        add(0, 3'b111, 0, 0, 0, 3'b010, 0, 0, 0);
        for (int k = 0; k < 4; k++) add(0, 3'b111, 3'b111, 10'(32 + k), 8'(8'h20 + k), 3'b010, 1, 10'(288 + k), 8'(8'h30 + k));
        add(0, 3'b101, 0, 0, 0, 3'b000, 0, 0, 0);
        add(0, 3'b111, 0, 0, 0, 3'b100, 0, 0, 0);
        for (int k = 0; k < 4; k++) add(0, 3'b111, 3'b111, 10'(48 + k), 8'(8'h40 + k), 3'b100, 1, 10'(560 + k), 8'(8'h60 + k));
        add(0, 3'b011, 0, 0, 0, 3'b000, 0, 0, 0);
        add(0, 3'b111, 0, 0, 0, 3'b001, 0, 0, 0);
        add(0, 3'b000, 0, 0, 0, 3'b000, 0, 0, 0);

        for (int v = 0; v < vq.size(); v++) begin
            rst = vq[v].rst;
            drive(vq[v].req, vq[v].wen, vq[v].base, vq[v].dbase);
            step();
            chk($sformatf("vec%0d gnt", v), 32'(gnt), 32'(vq[v].egnt));
            chk($sformatf("vec%0d wren", v), 32'(wren), 32'(vq[v].ewren));
            chk($sformatf("vec%0d flags", v), {29'd0, clr_busy, clr_done, timeout_err}, 32'd0);
            if (vq[v].ewren) begin
                chk($sformatf("vec%0d addr", v), 32'(wraddress), 32'(vq[v].eaddr));
                chk($sformatf("vec%0d data", v), 32'(data), 32'(vq[v].edata));
            end
        end

        // clear requested while requester 2 owns the port
        drive(3'b100, 3'b000, 0, 0);
        step();
        chk("clr_burst grant", 32'(gnt), 32'(3'b100));
        for (int k = 0; k < 3; k++) begin
            drive(3'b100, 3'b100, 10'(100 + k), 8'(8'h50 + k));
            clr_req = (k == 0);
            step();
            chk($sformatf("clr_burst wr%0d", k), {gnt, wren, clr_busy, wraddress, data},
                {3'b100, 1'b1, 1'b0, 10'(612 + k), 8'(8'h70 + k)});
        end
        clr_req = 1'b0;
        drive(3'b000, 3'b000, 0, 0);
        step();
        chk("clr_burst release", {29'd0, gnt}, 32'd0);
        nwr = 0; nbusy = 0; ndone = 0; gbad = 0; bad = 0; ea = '0;
        for (int k = 0; k < 1030; k++) begin
            step();
            if (wren) begin
                if (wraddress != ea || data != 8'h00 || !clr_busy) bad++;
                ea++;
                nwr++;
            end else if (clr_busy) bad++;
            if (clr_busy) nbusy++;
            if (clr_done) ndone++;
            if (gnt != 3'b000) gbad++;
        end
        chk("clear writes", nwr, 1024);
        chk("clear busy cycles", nbusy, 1024);
        chk("clear done pulses", ndone, 1);
        chk("clear bad cycles", bad, 0);
        chk("clear gnt", gbad, 0);

        // hold timeout: requester 0 never drops req, requester 1 waiting
        drive(3'b011, 3'b000, 0, 0);
        step();
        chk("timeout grant", 32'(gnt), 32'(3'b001));
        hold = 1;
        for (int k = 0; k < 40 && gnt == 3'b001; k++) begin
            step();
            if (gnt == 3'b001) begin
                hold++;
                if (timeout_err) chk("timeout early", 32'(timeout_err), 32'd0);
            end
        end
        chk("timeout hold cycles", hold, 16);
        chk("timeout revoke", {gnt, timeout_err}, {3'b000, 1'b1});
        step();
        chk("timeout next owner", {gnt, timeout_err}, {3'b010, 1'b0});

        // reset in the middle of a clear, then clear restarts from zero
        drive(3'b000, 3'b000, 0, 0);
        step();
        clr_req = 1'b1;
        step();
        clr_req = 1'b0;
        reached = 0;
        for (int k = 0; k < 400 && !reached; k++) begin
            if (wraddress == 10'd300 && wren) reached = 1;
            else step();
        end
        chk("midclear reached 300", reached, 1);
        rst = 1'b1;
        step();
        chk("midclear reset", {gnt, wren, clr_busy, clr_done, wraddress}, 16'd0);
        rst = 1'b0;
        clr_req = 1'b1;
        step();
        clr_req = 1'b0;
        chk("restart clear addr0", {wren, clr_busy, wraddress}, {1'b1, 1'b1, 10'd0});
        step();
        chk("restart clear addr1", {wren, clr_busy, wraddress}, {1'b1, 1'b1, 10'd1});

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
